// File: rtl/output_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : output_uart_tx
//  Description : Captures output_enable strobes ({core_id, data}) into a FIFO
//                and serialises each entry as a 3-byte 8N1 UART frame:
//                core_id (zero-extended), data[15:8], data[7:0].
//                Optional feature macro: OUTPUT_UART_DROP_COUNT_EN enables
//                the saturating dropped-entry counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module output_uart_tx #(
   parameter int NUM_CORES    = 16,
   parameter int FIFO_DEPTH   = 16,
   parameter int CLKS_PER_BIT = 434
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         output_enable,
   input  logic [$clog2(NUM_CORES)-1:0] output_core_id,
   input  logic [15:0]                  output_data_val,
   output logic                         uart_tx,
   output logic                         busy,
   output logic                         fifo_full,
   output logic [15:0]                  dropped_count
);

   localparam int c_cw = $clog2(NUM_CORES);
   localparam int c_aw = $clog2(FIFO_DEPTH);
   localparam int c_bw = $clog2(CLKS_PER_BIT);
   localparam int c_ew = c_cw + 16;

   localparam logic [c_aw:0]   c_depth     = (c_aw+1)'(FIFO_DEPTH);
   localparam logic [c_bw-1:0] c_baud_last = c_bw'(CLKS_PER_BIT - 1);

   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_start = 2'd1;
   localparam logic [1:0] c_data  = 2'd2;
   localparam logic [1:0] c_stop  = 2'd3;

   // FIFO
   logic [c_ew-1:0] r_mem [FIFO_DEPTH];
   logic [c_aw-1:0] r_wr_ptr;
   logic [c_aw-1:0] r_rd_ptr;
   logic [c_aw:0]   r_count;
   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   logic [c_ew-1:0] w_head;

   // transmitter
   logic [1:0]      r_state;
   logic [1:0]      w_state_next;
   logic [c_bw-1:0] r_baud;
   logic            w_tick;
   logic [2:0]      r_bit_idx;
   logic [1:0]      r_byte_idx;
   logic [7:0]      r_shift;
   logic [7:0]      w_shift_next;
   logic [7:0]      w_byte0;
   logic [15:0]     r_data;
   logic            r_tx;
   logic            w_tx_next;

   // Full/empty come from the registered count, so a push while full is
   // rejected even when the transmitter pops in the same cycle.
   assign w_full    = (r_count == c_depth);
   assign w_empty   = (r_count == '0);
   assign w_push    = output_enable && !w_full;
   assign w_head    = r_mem[r_rd_ptr];
   assign w_tick    = (r_baud == c_baud_last);
   assign fifo_full = w_full;
   assign uart_tx   = r_tx;

   // FIFO pointers and occupancy; the cluster side is never stalled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + c_aw'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + c_aw'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (c_aw+1)'(1);
            2'b01:   r_count <= r_count - (c_aw+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage; contents are meaningless once the pointers reset
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= {output_core_id, output_data_val};
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= c_idle;
      else
         r_state <= w_state_next;
   end

   // FSM next-state: one byte is START, 8 DATA bits, STOP; three bytes per frame
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_idle:  if (!w_empty) w_state_next = c_start;
         c_start: if (w_tick) w_state_next = c_data;
         c_data:  if (w_tick && (r_bit_idx == 3'd7)) w_state_next = c_stop;
         c_stop:  if (w_tick) w_state_next = (r_byte_idx == 2'd2) ? c_idle : c_start;
         default: w_state_next = c_idle;
      endcase
   end

   // FSM outputs: pop only from IDLE, line level follows the next state so
   // the registered pin changes on the same edge as the state
   always_comb begin
      busy = (r_state != c_idle);
      w_pop = (r_state == c_idle) && !w_empty;
      case (w_state_next)
         c_start: w_tx_next = 1'b0;
         c_data:  w_tx_next = w_shift_next[0];
         default: w_tx_next = 1'b1;
      endcase
   end

   // Shifter next value: load byte0 on pop, shift within a byte, reload at STOP
   always_comb begin
      w_byte0 = '0;
      w_byte0[c_cw-1:0] = w_head[c_ew-1:16];
      w_shift_next = r_shift;
      if (w_pop)
         w_shift_next = w_byte0;
      else if ((r_state == c_data) && w_tick && (r_bit_idx != 3'd7))
         w_shift_next = {1'b0, r_shift[7:1]};
      else if ((r_state == c_stop) && w_tick && (r_byte_idx != 2'd2))
         w_shift_next = (r_byte_idx == 2'd0) ? r_data[15:8] : r_data[7:0];
   end

   // Baud counter, bit/byte indices, frame payload and registered line driver
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_baud     <= '0;
         r_bit_idx  <= '0;
         r_byte_idx <= '0;
         r_shift    <= '0;
         r_data     <= '0;
         r_tx       <= 1'b1;
      end else begin
         r_shift <= w_shift_next;
         r_tx    <= w_tx_next;
         if ((r_state == c_idle) || w_tick)
            r_baud <= '0;
         else
            r_baud <= r_baud + c_bw'(1);
         if (w_pop) begin
            r_data     <= w_head[15:0];
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
         end else begin
            if ((r_state == c_data) && w_tick)
               r_bit_idx <= r_bit_idx + 3'd1;
            if ((r_state == c_stop) && w_tick)
               r_byte_idx <= r_byte_idx + 2'd1;
         end
      end
   end

`ifdef OUTPUT_UART_DROP_COUNT_EN
   logic [15:0] r_dropped;

   // Count push attempts rejected by a full FIFO, saturating at all-ones
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_dropped <= '0;
      else if (output_enable && w_full && (r_dropped != 16'hFFFF))
         r_dropped <= r_dropped + 16'd1;
   end

   assign dropped_count = r_dropped;
`else
   assign dropped_count = 16'h0000;
`endif

endmodule
`default_nettype wire
